i2c_master_write: RTL and testbench

Single-wire, clock-synchronous write initiator for the team's simplified I2C link. It is the counterpart of the existing write-only `slave` responder. On a `start` request it drives one frame on the shared open-drain `sda` line: START, 7-bit slave address plus W bit, 8-bit register address, 8-bit data, and STOP. It samples the responder's ACK after each byte. Both ends run from the common `clk`, and one bit is transferred per clock (no SCL wire).

---
 rtl/i2c_master_write.sv | 154 +++++++++++++++
 tb/tb_i2c_master_write.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_write.sv
// Write-only initiator for the single-wire, one-bit-per-clock I2C link:
// START, address+W, register byte, data byte (each followed by an ACK slot), STOP.
module i2c_master_write #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] slave_addr,
  input  logic [DATA_W-1:0] reg_addr,
  input  logic [DATA_W-1:0] wdata,
  inout  wire               sda,
  output logic              busy,
  output logic              done,
  output logic              ack_err
);

  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_RW, S_ACK1, S_REG, S_ACK2,
    S_DATA, S_ACK3, S_STOP_L, S_STOP_H, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_sh_q, addr_sh_d;
  logic [DATA_W-1:0] reg_sh_q, reg_sh_d;
  logic [DATA_W-1:0] data_sh_q, data_sh_d;
  logic              sda_oe_q, sda_oe_d;
  logic              sda_o_q, sda_o_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ack_err_q, ack_err_d;
  logic              sda_in;

  assign sda_in = sda;
  assign sda    = sda_oe_q ? sda_o_q : 1'bz;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_sh_d = addr_sh_q;
    reg_sh_d  = reg_sh_q;
    data_sh_d = data_sh_q;
    ack_err_d = ack_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_START;
          addr_sh_d = slave_addr;
          reg_sh_d  = reg_addr;
          data_sh_d = wdata;
          ack_err_d = 1'b0;
        end
      end
      S_START: begin
        state_d = S_ADDR;
        cnt_d   = CNT_W'(ADDR_W - 1);
      end
      S_ADDR: begin
        addr_sh_d = addr_sh_q << 1;
        if (cnt_q == '0) state_d = S_RW;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_RW: state_d = S_ACK1;
      S_ACK1: begin
        if (sda_in == 1'b0) begin
          state_d = S_REG;
          cnt_d   = CNT_W'(DATA_W - 1);
        end else begin
          state_d   = S_STOP_L;
          ack_err_d = 1'b1;
        end
      end
      S_REG: begin
        reg_sh_d = reg_sh_q << 1;
        if (cnt_q == '0) state_d = S_ACK2;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_ACK2: begin
        if (sda_in == 1'b0) begin
          state_d = S_DATA;
          cnt_d   = CNT_W'(DATA_W - 1);
        end else begin
          state_d   = S_STOP_L;
          ack_err_d = 1'b1;
        end
      end
      S_DATA: begin
        data_sh_d = data_sh_q << 1;
        if (cnt_q == '0) state_d = S_ACK3;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_ACK3: begin
        state_d = S_STOP_L;
        if (sda_in != 1'b0) ack_err_d = 1'b1;
      end
      S_STOP_L: state_d = S_STOP_H;
      S_STOP_H: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Line drive is decoded from the next state so sda leaves a flop directly.
  always_comb begin
    sda_oe_d = 1'b1;
    sda_o_d  = 1'b0;
    case (state_d)
      S_IDLE, S_ACK1, S_ACK2, S_ACK3, S_DONE: sda_oe_d = 1'b0;
      S_ADDR:   sda_o_d = addr_sh_d[ADDR_W-1];
      S_REG:    sda_o_d = reg_sh_d[DATA_W-1];
      S_DATA:   sda_o_d = data_sh_d[DATA_W-1];
      S_STOP_H: sda_o_d = 1'b1;
      default:  sda_o_d = 1'b0;
    endcase
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_sh_q <= '0;
      reg_sh_q  <= '0;
      data_sh_q <= '0;
      sda_oe_q  <= 1'b0;
      sda_o_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_sh_q <= addr_sh_d;
      reg_sh_q  <= reg_sh_d;
      data_sh_q <= data_sh_d;
      sda_oe_q  <= sda_oe_d;
      sda_o_q   <= sda_o_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_master_write.sv
// Scoreboard bench: each frame request pushes its per-cycle expected line/flag
// values; a monitor pops one entry per clock, plays the responder, and compares.
module tb_i2c_master_write;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [6:0] slave_addr;
  logic [7:0] reg_addr;
  logic [7:0] wdata;
  wire        sda;
  logic       busy, done, ack_err;
  logic       resp_low;

  pullup (sda);
  assign sda = resp_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_master_write dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .slave_addr (slave_addr),
    .reg_addr   (reg_addr),
    .wdata      (wdata),
    .sda        (sda),
    .busy       (busy),
    .done       (done),
    .ack_err    (ack_err)
  );

  typedef struct packed {
    logic sda;
    logic busy;
    logic done;
    logic resp;
    logic err;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   cur_valid;
  int   total = 0;
  int   bad   = 0;

  task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic push_ent(logic s, logic b, logic d, logic r, logic e);
    exp_t x;
    x.sda = s; x.busy = b; x.done = d; x.resp = r; x.err = e;
    exp_q.push_back(x);
  endtask

  // nack_at: 0 = responder ACKs everything, k = responder leaves ACK slot k released
  task automatic push_frame(logic [6:0] a, logic [7:0] ra, logic [7:0] wd, int nack_at);
    logic       err;
    logic [7:0] bits;
    err = 1'b0;
    push_ent(1'b0, 1'b1, 1'b0, 1'b0, err);
    for (int k = 0; k < 3; k++) begin
      bits = (k == 0) ? {a, 1'b0} : (k == 1) ? ra : wd;
      for (int i = 7; i >= 0; i--) push_ent(bits[i], 1'b1, 1'b0, 1'b0, err);
      if (nack_at == k + 1) begin
        push_ent(1'b1, 1'b1, 1'b0, 1'b0, err);
        err = 1'b1;
        break;
      end
      push_ent(1'b0, 1'b1, 1'b0, 1'b1, err);
    end
    push_ent(1'b0, 1'b1, 1'b0, 1'b0, err);
    push_ent(1'b1, 1'b1, 1'b0, 1'b0, err);
    push_ent(1'b1, 1'b0, 1'b1, 1'b0, err);
    push_ent(1'b1, 1'b0, 1'b0, 1'b0, err);
  endtask

  // Monitor + responder: one scoreboard entry per clock cycle.
  initial begin
    cur_valid = 1'b0;
    resp_low  = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        exp_q.delete();
        cur_valid = 1'b0;
        resp_low  = 1'b0;
      end else if (exp_q.size() > 0) begin
        cur       = exp_q.pop_front();
        cur_valid = 1'b1;
        resp_low  = cur.resp;
      end else begin
        cur_valid = 1'b0;
        resp_low  = 1'b0;
      end
      @(negedge clk);
      if (cur_valid && rst) begin
        check_val("sda",     {31'd0, sda},     {31'd0, cur.sda});
        check_val("busy",    {31'd0, busy},    {31'd0, cur.busy});
        check_val("done",    {31'd0, done},    {31'd0, cur.done});
        check_val("ack_err", {31'd0, ack_err}, {31'd0, cur.err});
      end
    end
  end

  task automatic wait_drain(string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || cur_valid) && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    check_val({tag, "_drain"}, {31'd0, n < 200}, 32'd1);
  endtask

  task automatic drive_req(logic [6:0] a, logic [7:0] ra, logic [7:0] wd);
    @(negedge clk);
    slave_addr = a;
    reg_addr   = ra;
    wdata      = wd;
    start      = 1'b1;
  endtask

  task automatic run_frame(string name, logic [6:0] a, logic [7:0] ra, logic [7:0] wd, int nack_at);
    drive_req(a, ra, wd);
    push_frame(a, ra, wd, nack_at);
    @(posedge clk); #2;
    start = 1'b0;
    wait_drain(name);
    $display("frame %s addr=%h reg=%h data=%h nack_at=%0d ack_err=%0b", name, a, ra, wd, nack_at, ack_err);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0;
    slave_addr = '0; reg_addr = '0; wdata = '0;
    #2;
    check_val("rst_sda",     {31'd0, sda},     32'd1);
    check_val("rst_busy",    {31'd0, busy},    32'd0);
    check_val("rst_done",    {31'd0, done},    32'd0);
    check_val("rst_ack_err", {31'd0, ack_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_frame("nominal",   7'h2A, 8'hBE, 8'h9A, 0);
    run_frame("addr_nack", 7'h2A, 8'hBE, 8'h9A, 1);
    run_frame("data_nack", 7'h55, 8'h01, 8'hFF, 3);
    run_frame("clear_err", 7'h13, 8'h5C, 8'h3C, 0);
    run_frame("reg_nack",  7'h7F, 8'h00, 8'h81, 2);

    // start held high through two frames: second accept at the cycle-32 edge
    drive_req(7'h11, 8'h22, 8'h33);
    push_frame(7'h11, 8'h22, 8'h33, 0);
    push_frame(7'h11, 8'h22, 8'h33, 0);
    @(posedge clk); #2;
    repeat (32) @(posedge clk);
    #2 start = 1'b0;
    wait_drain("held");
    $display("frame held two back-to-back frames addr=11 reg=22 data=33");

    // start pulsed mid-frame and in the DONE cycle: both ignored
    drive_req(7'h4C, 8'hE7, 8'h18);
    push_frame(7'h4C, 8'hE7, 8'h18, 0);
    push_ent(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #2 start = 1'b0;
    repeat (14) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    repeat (15) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    wait_drain("ignored_start");
    $display("frame ignored_start addr=4c reg=e7 data=18");

    // inputs change after accept: frame uses the captured values
    drive_req(7'h2A, 8'h5A, 8'hA5);
    push_frame(7'h2A, 8'h5A, 8'hA5, 0);
    @(posedge clk); #2 start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    slave_addr = '0; reg_addr = '0; wdata = '0;
    wait_drain("input_change");
    $display("frame input_change addr=2a reg=5a data=a5");

    // reset in cycle 14 (mid-REG): immediate release, no STOP, no done
    drive_req(7'h2A, 8'hBE, 8'h9A);
    push_frame(7'h2A, 8'hBE, 8'h9A, 0);
    @(posedge clk); #2 start = 1'b0;
    repeat (13) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_val("midrst_sda",  {31'd0, sda},  32'd1);
    check_val("midrst_busy", {31'd0, busy}, 32'd0);
    check_val("midrst_done", {31'd0, done}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check_val("inrst_busy", {31'd0, busy}, 32'd0);
      check_val("inrst_done", {31'd0, done}, 32'd0);
      check_val("inrst_sda",  {31'd0, sda},  32'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    check_val("postrst_busy", {31'd0, busy}, 32'd0);
    $display("frame reset_mid_reg aborted");
    run_frame("after_reset", 7'h2A, 8'hBE, 8'h9A, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "bench timeout");
  end

endmodule
